// File: rtl/gcd_unit.sv
// Iterative subtract-and-swap Euclid GCD engine with a start/done handshake.
// One subtraction per clock; result, coprime flag and step count are held until the next start.
module gcd_unit #(
  parameter int WIDTH = 16
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             coprime,
  output logic [WIDTH-1:0] steps
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] ZERO     = '0;
  localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] STEP_MAX = '1;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] a_next;
  logic [WIDTH-1:0] b_next;
  logic [WIDTH-1:0] count_next;
  logic [WIDTH-1:0] count_inc;
  logic [WIDTH-1:0] result_next;
  logic             coprime_next;
  logic             load;
  logic             finish;
  logic [WIDTH-1:0] finish_val;

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      a_q     <= ZERO;
      b_q     <= ZERO;
      count_q <= ZERO;
      result  <= ZERO;
      coprime <= 1'b0;
    end else begin
      a_q     <= a_next;
      b_q     <= b_next;
      count_q <= count_next;
      result  <= result_next;
      coprime <= coprime_next;
    end
  end

  // The counter never wraps; legal inputs cannot reach the ceiling anyway.
  assign count_inc = (count_q == STEP_MAX) ? count_q : count_q + ONE;

  always_comb begin
    state_next   = state;
    a_next       = a_q;
    b_next       = b_q;
    count_next   = count_q;
    result_next  = result;
    coprime_next = coprime;
    load         = 1'b0;
    finish       = 1'b0;
    finish_val   = ZERO;

    case (state)
      IDLE: begin
        load = start;
      end

      RUN: begin
        // Zero checks come first so a zero operand never enters the subtract loop.
        if (b_q == ZERO) begin
          finish     = 1'b1;
          finish_val = a_q;
        end else if (a_q == ZERO) begin
          finish     = 1'b1;
          finish_val = b_q;
        end else if (a_q == b_q) begin
          finish     = 1'b1;
          finish_val = a_q;
        end else if (a_q > b_q) begin
          a_next     = a_q - b_q;
          count_next = count_inc;
        end else begin
          b_next     = b_q - a_q;
          count_next = count_inc;
        end
      end

      DONE: begin
        state_next = IDLE;
        load       = start;
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    if (finish) begin
      result_next  = finish_val;
      coprime_next = (finish_val == ONE);
      state_next   = DONE;
    end

    // Accepting a new pair clears the previously held outputs.
    if (load) begin
      a_next       = a_in;
      b_next       = b_in;
      count_next   = ZERO;
      result_next  = ZERO;
      coprime_next = 1'b0;
      state_next   = RUN;
    end
  end

  assign busy  = (state == RUN);
  assign done  = (state == DONE);
  assign steps = count_q;

endmodule

// File: tb/tb_gcd_unit.sv
// Self-checking bench for gcd_unit: directed vector table, hand-written handshake
// sequences and randomized pairs checked against a quotient-based Euclid model.
module tb_gcd_unit;

  logic        CLK;
  logic        reset;
  logic        start;
  logic [15:0] a_in;
  logic [15:0] b_in;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic        coprime;
  logic [15:0] steps;

  int errors = 0;
  int checks = 0;
  bit poke_busy;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] exp_result;
    logic        exp_coprime;
    logic [15:0] exp_steps;
    int          poke_at;
  } vec_t;

  vec_t vecs[$];

  gcd_unit #(.WIDTH(16)) dut (
    .CLK     (CLK),
    .reset   (reset),
    .start   (start),
    .a_in    (a_in),
    .b_in    (b_in),
    .busy    (busy),
    .done    (done),
    .result  (result),
    .coprime (coprime),
    .steps   (steps)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic checkOutput(input string name, input int unsigned actual, input int unsigned expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Classic division-based Euclid: subtractive steps equal the sum of quotients minus one.
  function automatic void refModel(input int unsigned a, input int unsigned b,
                                   output int unsigned g, output int unsigned s);
    int unsigned x, y, r;
    if (a == 0 || b == 0) begin
      g = (a == 0) ? b : a;
      s = 0;
    end else begin
      x = (a > b) ? a : b;
      y = (a > b) ? b : a;
      s = 0;
      while (y != 0) begin
        s += x / y;
        r = x % y;
        x = y;
        y = r;
      end
      g = x;
      s = s - 1;
    end
  endfunction

  // Issues one pair and waits for done; lat counts edges after the accepting edge.
  task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b, input int poke_at,
                               output logic [15:0] r, output logic c, output logic [15:0] s,
                               output int lat, output bit overlap, output bit single);
    int j;
    @(negedge CLK);
    start = 1'b1;
    a_in  = a;
    b_in  = b;
    @(posedge CLK);
    @(negedge CLK);
    start   = 1'b0;
    j       = 0;
    overlap = 1'b0;
    r = '0; c = 1'b0; s = '0;
    while (!done && j < 70000) begin
      if (busy && done) overlap = 1'b1;
      if (j == poke_at + 1) poke_busy = busy;
      if (j == poke_at) begin
        start = 1'b1;
        a_in  = 16'd1;
        b_in  = 16'd1;
      end else begin
        start = 1'b0;
      end
      @(negedge CLK);
      j++;
    end
    start = 1'b0;
    if (!done) begin
      lat    = -1;
      single = 1'b0;
      $display("[TB] FAIL timeout: got no done, expected done for a=%0d b=%0d", a, b);
    end else begin
      if (busy && done) overlap = 1'b1;
      lat = j;
      r   = result;
      c   = coprime;
      s   = steps;
      @(negedge CLK);
      single = !done;
    end
  endtask

  task automatic runAndCheck(input string tag, input logic [15:0] a, input logic [15:0] b,
                             input logic [15:0] er, input logic ec, input logic [15:0] es,
                             input int poke_at);
    logic [15:0] r, s;
    logic        c;
    int          lat;
    bit          overlap, single;
    applyStimulus(a, b, poke_at, r, c, s, lat, overlap, single);
    checkOutput({tag, " result"}, r, er);
    checkOutput({tag, " coprime"}, c, ec);
    checkOutput({tag, " steps"}, s, es);
    checkOutput({tag, " latency"}, lat, es + 1);
    checkOutput({tag, " busy_done_overlap"}, overlap, 0);
    checkOutput({tag, " done_single"}, single, 1);
  endtask

  initial begin
    logic [15:0] ra, rb;
    int unsigned g, s;
    bit          saw_done;

    vecs.push_back('{16'd12,    16'd18, 16'd6,  1'b0, 16'd2,     -1});
    vecs.push_back('{16'd30030, 16'd2,  16'd2,  1'b0, 16'd15014, -1});
    vecs.push_back('{16'd30030, 16'd17, 16'd1,  1'b1, 16'd1775,  50});
    vecs.push_back('{16'd0,     16'd5,  16'd5,  1'b0, 16'd0,     -1});
    vecs.push_back('{16'd0,     16'd0,  16'd0,  1'b0, 16'd0,     -1});
    vecs.push_back('{16'd5,     16'd0,  16'd5,  1'b0, 16'd0,     -1});
    vecs.push_back('{16'd7,     16'd7,  16'd7,  1'b0, 16'd0,     -1});
    vecs.push_back('{16'd9,     16'd6,  16'd3,  1'b0, 16'd2,     -1});
    vecs.push_back('{16'd1,     16'd1,  16'd1,  1'b1, 16'd0,     -1});
    vecs.push_back('{16'd100,   16'd1,  16'd1,  1'b1, 16'd99,    -1});
    vecs.push_back('{16'd48,    16'd180, 16'd12, 1'b0, 16'd6,    -1});

    reset = 1'b1;
    start = 1'b0;
    a_in  = '0;
    b_in  = '0;
    poke_busy = 1'b0;
    #12;
    checkOutput("reset busy", busy, 0);
    checkOutput("reset done", done, 0);
    checkOutput("reset result", result, 0);
    checkOutput("reset coprime", coprime, 0);
    checkOutput("reset steps", steps, 0);
    @(negedge CLK);
    reset = 1'b0;

    // Abort a long computation with an asynchronous reset mid-cycle.
    @(negedge CLK);
    start = 1'b1; a_in = 16'd30030; b_in = 16'd2;
    @(posedge CLK);
    @(negedge CLK);
    start = 1'b0;
    repeat (100) @(negedge CLK);
    checkOutput("pre-abort busy", busy, 1);
    #2 reset = 1'b1;
    #1;
    checkOutput("abort busy", busy, 0);
    checkOutput("abort steps", steps, 0);
    checkOutput("abort done", done, 0);
    @(negedge CLK);
    reset = 1'b0;
    saw_done = 1'b0;
    repeat (20) begin
      @(negedge CLK);
      if (done || busy) saw_done = 1'b1;
    end
    checkOutput("abort no_done", saw_done, 0);
    runAndCheck("after_abort 12,18", 16'd12, 16'd18, 16'd6, 1'b0, 16'd2, -1);

    for (int i = 0; i < vecs.size(); i++) begin
      runAndCheck($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].exp_result,
                  vecs[i].exp_coprime, vecs[i].exp_steps, vecs[i].poke_at);
      if (vecs[i].poke_at >= 0) checkOutput($sformatf("vec%0d busy_after_poke", i), poke_busy, 1);
    end

    // start held high across DONE: back-to-back acceptance with no IDLE cycle.
    @(negedge CLK);
    start = 1'b1; a_in = 16'd7; b_in = 16'd7;
    @(posedge CLK);
    @(negedge CLK);
    checkOutput("held j0 busy", busy, 1);
    checkOutput("held j0 result_cleared", result, 0);
    @(negedge CLK);
    checkOutput("held first done", done, 1);
    checkOutput("held first result", result, 7);
    checkOutput("held first steps", steps, 0);
    a_in = 16'd9; b_in = 16'd6;
    @(negedge CLK);
    checkOutput("held reaccept busy", busy, 1);
    checkOutput("held reaccept done", done, 0);
    start = 1'b0;
    repeat (3) @(negedge CLK);
    checkOutput("held second done", done, 1);
    checkOutput("held second result", result, 3);
    checkOutput("held second steps", steps, 2);
    checkOutput("held second coprime", coprime, 0);
    @(negedge CLK);
    checkOutput("held second single", done, 0);
    checkOutput("held idle busy", busy, 0);
    checkOutput("held hold result", result, 3);

    for (int i = 0; i < 520; i++) begin
      if (i % 8 == 0) begin
        ra = 16'($urandom_range(255, 0));
        rb = 16'($urandom_range(255, 0));
      end else begin
        ra = 16'($urandom_range(65535, 256));
        rb = 16'($urandom_range(65535, 256));
      end
      refModel(ra, rb, g, s);
      runAndCheck($sformatf("rnd%0d %0d,%0d", i, ra, rb), ra, rb, 16'(g), (g == 1), 16'(s), -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
